// File: rtl/qam_pkg.sv
// Shared types and helpers for the QAM symbol mapper.
// Mode encoding, bits-per-symbol and per-axis Gray levels.
package qam_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK    = 2'd0,
    MODE_QPSK    = 2'd1,
    MODE_QAM16   = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    LVL_POS_OUTER = 2'd0,
    LVL_POS_INNER = 2'd1,
    LVL_NEG_INNER = 2'd2,
    LVL_NEG_OUTER = 2'd3
  } level_e;

  function automatic logic [2:0] bps_of(mode_e m);
    logic [2:0] r;
    case (m)
      MODE_QPSK:  r = 3'd2;
      MODE_QAM16: r = 3'd4;
      default:    r = 3'd1;
    endcase
    return r;
  endfunction

  // Gray code per axis: 00,01,11,10 walk from +outer to -outer
  function automatic level_e gray_level(logic [1:0] b);
    level_e r;
    case (b)
      2'b00:   r = LVL_POS_OUTER;
      2'b01:   r = LVL_POS_INNER;
      2'b11:   r = LVL_NEG_INNER;
      default: r = LVL_NEG_OUTER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// Word-in / symbol-out stream bundle of the QAM mapper.
// master drives words and out_ready; slave is the mapper.
interface qam_symbol_mapper_if #(
  parameter int WORD_W = 32,
  parameter int AMP_W  = 16
);

  logic [WORD_W-1:0]       in_data;
  logic [1:0]              in_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [AMP_W-1:0] out_i;
  logic signed [AMP_W-1:0] out_q;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    error;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_i, out_q, out_last, out_valid, error
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_i, out_q, out_last, out_valid, error
  );

endinterface

// File: rtl/qam_point_lut.sv
// Combinational constellation lookup: mode + symbol bits -> I/Q.
// Bit 0 is the first-consumed bit; a 0 bit maps to positive amplitude.
module qam_point_lut
  import qam_pkg::*;
#(
  parameter int AMP_W     = 16,
  parameter int AMP_OUTER = 12288,
  parameter int AMP_INNER = 4096
) (
  input  mode_e                   mode_i,
  input  logic [3:0]              bits_i,
  output logic signed [AMP_W-1:0] i_o,
  output logic signed [AMP_W-1:0] q_o
);

  localparam logic signed [AMP_W-1:0] P_OUT = AMP_W'(AMP_OUTER);
  localparam logic signed [AMP_W-1:0] N_OUT = AMP_W'(-AMP_OUTER);
  localparam logic signed [AMP_W-1:0] P_IN  = AMP_W'(AMP_INNER);
  localparam logic signed [AMP_W-1:0] N_IN  = AMP_W'(-AMP_INNER);

  function automatic logic signed [AMP_W-1:0] lvl_amp(level_e l);
    logic signed [AMP_W-1:0] r;
    case (l)
      LVL_POS_OUTER: r = P_OUT;
      LVL_POS_INNER: r = P_IN;
      LVL_NEG_INNER: r = N_IN;
      default:       r = N_OUT;
    endcase
    return r;
  endfunction

  // Select the constellation point for the current mode
  always_comb begin
    i_o = '0;
    q_o = '0;
    unique case (1'b1)
      mode_i == MODE_QPSK: begin
        i_o = bits_i[0] ? N_OUT : P_OUT;
        q_o = bits_i[1] ? N_OUT : P_OUT;
      end
      mode_i == MODE_QAM16: begin
        i_o = lvl_amp(gray_level(bits_i[1:0]));
        q_o = lvl_amp(gray_level(bits_i[3:2]));
      end
      default: begin
        i_o = bits_i[0] ? N_OUT : P_OUT;
      end
    endcase
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// Serialises data words LSB-first into BPSK/QPSK/16-QAM symbols.
// Registered I/Q output stream with backpressure, no bubble between words.
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int AMP_W     = 16,
  parameter int AMP_OUTER = 12288,
  parameter int AMP_INNER = 4096
) (
  input logic                clk,
  input logic                rst,
  qam_symbol_mapper_if.slave bus
);

  localparam int CNT_W = $clog2(WORD_W);

  state_e                  state_q;
  mode_e                   mode_q;
  logic [WORD_W-1:0]       shift_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [AMP_W-1:0] i_q;
  logic signed [AMP_W-1:0] q_q;
  logic                    last_q;
  logic                    valid_q;
  logic                    err_q;

  mode_e                   in_mode_w;
  logic [CNT_W-1:0]        cnt_init_w;
  logic                    load_w;
  logic                    last_w;
  logic                    rdy_w;
  logic                    accept_w;
  logic signed [AMP_W-1:0] lut_i_w;
  logic signed [AMP_W-1:0] lut_q_w;

  assign in_mode_w = mode_e'(bus.in_mode);

  // The output slot is free when empty or being drained this cycle
  assign load_w   = (state_q == S_RUN) && (!valid_q || bus.out_ready);
  assign last_w   = load_w && (cnt_q == '0);
  assign rdy_w    = !rst && ((state_q == S_IDLE) || last_w);
  assign accept_w = bus.in_valid && rdy_w;

  // Symbols per word minus one, for the incoming mode
  always_comb begin
    cnt_init_w = CNT_W'(WORD_W - 1);
    unique case (1'b1)
      in_mode_w == MODE_QPSK:  cnt_init_w = CNT_W'(WORD_W / 2 - 1);
      in_mode_w == MODE_QAM16: cnt_init_w = CNT_W'(WORD_W / 4 - 1);
      default: ;
    endcase
  end

  qam_point_lut #(
    .AMP_W    (AMP_W),
    .AMP_OUTER(AMP_OUTER),
    .AMP_INNER(AMP_INNER)
  ) u_lut (
    .mode_i(mode_q),
    .bits_i(shift_q[3:0]),
    .i_o   (lut_i_w),
    .q_o   (lut_q_w)
  );

  // Word/shift FSM with registered symbol output and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_BPSK;
      shift_q <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      q_q     <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept_w && (in_mode_w == MODE_ILLEGAL);
      if (load_w) begin
        i_q     <= lut_i_w;
        q_q     <= lut_q_w;
        last_q  <= (cnt_q == '0);
        valid_q <= 1'b1;
        shift_q <= shift_q >> bps_of(mode_q);
        cnt_q   <= cnt_q - CNT_W'(1);
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept_w && (in_mode_w != MODE_ILLEGAL)) begin
        shift_q <= bus.in_data;
        mode_q  <= in_mode_w;
        cnt_q   <= cnt_init_w;
        state_q <= S_RUN;
      end else if (last_w) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign bus.in_ready  = rdy_w;
  assign bus.out_i     = i_q;
  assign bus.out_q     = q_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Self-checking bench for qam_symbol_mapper.
// Directed vectors, corner sequences and a randomized scoreboard run.
module tb_qam_symbol_mapper;

  localparam int OUTER = 12288;
  localparam int INNER = 4096;

  logic clk;
  logic rst;

  qam_symbol_mapper_if #(.WORD_W(32), .AMP_W(16)) bus ();

  qam_symbol_mapper #(
    .WORD_W   (32),
    .AMP_W    (16),
    .AMP_OUTER(OUTER),
    .AMP_INNER(INNER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    bit last;
  } sym_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    int          count;
  } word_t;

  typedef struct {
    int wrd;
    int idx;
    int ei;
    int eq;
    bit el;
  } vec_t;

  sym_t exp_q[$];
  sym_t cap_q[$];

  int checks = 0;
  int errors = 0;
  int n_hs   = 0;
  int n_last = 0;
  bit acc_now;
  bit exp_err;
  bit stall_prev;
  sym_t prev_sym;

  task automatic fail(input string name, input string msg);
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic int axis16(input int v);
    int mag;
    mag = (v & 1) ? INNER : OUTER;
    return (v & 2) ? -mag : mag;
  endfunction

  function automatic int bit_amp(input int b);
    return b ? -OUTER : OUTER;
  endfunction

  // Expand one accepted word into its expected symbol list
  task automatic model_word(input logic [1:0] m, input logic [31:0] d);
    int bps;
    int n;
    int sym;
    sym_t s;
    bps = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    n = 32 / bps;
    for (int k = 0; k < n; k++) begin
      sym = int'((d >> (k * bps)) & ((32'd1 << bps) - 32'd1));
      case (m)
        2'd0: begin
          s.i = bit_amp(sym & 1);
          s.q = 0;
        end
        2'd1: begin
          s.i = bit_amp(sym & 1);
          s.q = bit_amp((sym >> 1) & 1);
        end
        default: begin
          s.i = axis16(sym & 3);
          s.q = axis16((sym >> 2) & 3);
        end
      endcase
      s.last = (k == n - 1);
      exp_q.push_back(s);
    end
  endtask

  // One clock: observe this cycle's handshakes, then step to next negedge
  task automatic tick();
    sym_t a;
    sym_t e;
    #1;
    acc_now = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
      stall_prev = 1'b0;
    end else begin
      checks++;
      if (bus.error !== exp_err)
        fail("error_pulse", $sformatf("got %0b want %0b", bus.error, exp_err));
      exp_err = 1'b0;
      a.i = int'(bus.out_i);
      a.q = int'(bus.out_q);
      a.last = bus.out_last;
      if (stall_prev) begin
        checks++;
        if (!bus.out_valid || a.i != prev_sym.i || a.q != prev_sym.q ||
            a.last != prev_sym.last)
          fail("stall_hold", $sformatf("got v%0b %0d,%0d,%0b want %0d,%0d,%0b",
               bus.out_valid, a.i, a.q, a.last,
               prev_sym.i, prev_sym.q, prev_sym.last));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        if (a.last) n_last++;
        cap_q.push_back(a);
        checks++;
        if (exp_q.size() == 0) begin
          fail("sb_extra", $sformatf("got %0d,%0d,%0b want none", a.i, a.q, a.last));
        end else begin
          e = exp_q.pop_front();
          if (a.i != e.i || a.q != e.q || a.last != e.last)
            fail("sb_symbol", $sformatf("got %0d,%0d,%0b want %0d,%0d,%0b",
                 a.i, a.q, a.last, e.i, e.q, e.last));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_sym = a;
      if (bus.in_valid && bus.in_ready) begin
        acc_now = 1'b1;
        if (bus.in_mode == 2'd3) exp_err = 1'b1;
        else model_word(bus.in_mode, bus.in_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [1:0] m, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.in_mode = m;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (acc_now) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) fail("accept_timeout", "got no accept want accept");
  endtask

  task automatic wait_last(input int base);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (n_last > base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) fail("last_timeout", "got no last want last");
  endtask

  word_t words[3];
  vec_t  vecs[12];

  initial begin
    int base;
    int cnt;
    int run;
    bit seen;
    int hs0;

    words[0] = '{2'd0, 32'h0000_0001, 32};
    words[1] = '{2'd1, 32'h0000_0006, 16};
    words[2] = '{2'd2, 32'h0000_36C0, 8};
    vecs[0]  = '{0, 0,  -OUTER, 0, 1'b0};
    vecs[1]  = '{0, 1,   OUTER, 0, 1'b0};
    vecs[2]  = '{0, 31,  OUTER, 0, 1'b1};
    vecs[3]  = '{1, 0,   OUTER, -OUTER, 1'b0};
    vecs[4]  = '{1, 1,  -OUTER,  OUTER, 1'b0};
    vecs[5]  = '{1, 2,   OUTER,  OUTER, 1'b0};
    vecs[6]  = '{1, 15,  OUTER,  OUTER, 1'b1};
    vecs[7]  = '{2, 0,   OUTER,  OUTER, 1'b0};
    vecs[8]  = '{2, 1,   OUTER, -INNER, 1'b0};
    vecs[9]  = '{2, 2,  -OUTER,  INNER, 1'b0};
    vecs[10] = '{2, 3,  -INNER,  OUTER, 1'b0};
    vecs[11] = '{2, 7,   OUTER,  OUTER, 1'b1};

    rst = 1'b1;
    bus.in_data = '0;
    bus.in_mode = 2'd0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    exp_err = 1'b0;
    stall_prev = 1'b0;
    @(negedge clk);
    tick();
    tick();
    #1;
    checks++;
    if (bus.in_ready !== 1'b0)
      fail("rst_in_ready", $sformatf("got %0b want 0", bus.in_ready));
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_i !== 16'sd0 ||
        bus.out_q !== 16'sd0 || bus.out_last !== 1'b0 || bus.error !== 1'b0)
      fail("reset_state", $sformatf("got rdy%0b v%0b %0d,%0d,%0b e%0b want 1 0 0,0,0 0",
           bus.in_ready, bus.out_valid, bus.out_i, bus.out_q, bus.out_last, bus.error));
    @(negedge clk);

    // Directed words from the vector table
    for (int w = 0; w < 3; w++) begin
      cap_q.delete();
      base = n_last;
      bus.out_ready = 1'b1;
      send_word(words[w].mode, words[w].data);
      wait_last(base);
      tick();
      checks++;
      if (cap_q.size() != words[w].count)
        fail("sym_count", $sformatf("word %0d got %0d want %0d",
             w, cap_q.size(), words[w].count));
      for (int v = 0; v < 12; v++) begin
        if (vecs[v].wrd == w) begin
          checks++;
          if (vecs[v].idx >= cap_q.size())
            fail("vec_missing", $sformatf("word %0d idx %0d got none", w, vecs[v].idx));
          else if (cap_q[vecs[v].idx].i != vecs[v].ei ||
                   cap_q[vecs[v].idx].q != vecs[v].eq ||
                   cap_q[vecs[v].idx].last != vecs[v].el)
            fail("vec_symbol", $sformatf("word %0d idx %0d got %0d,%0d,%0b want %0d,%0d,%0b",
                 w, vecs[v].idx, cap_q[vecs[v].idx].i, cap_q[vecs[v].idx].q,
                 cap_q[vecs[v].idx].last, vecs[v].ei, vecs[v].eq, vecs[v].el));
        end
      end
    end

    // Backpressure: out_ready pattern 1,0,0,1 repeating
    hs0 = n_hs;
    bus.out_ready = 1'b1;
    bus.in_mode = 2'd1;
    bus.in_data = 32'hA5C3_1E97;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      bus.out_ready = ((t % 4) == 0) || ((t % 4) == 3);
      if (acc_now) bus.in_valid = 1'b0;
      tick();
      if (n_hs - hs0 >= 16 && !bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (n_hs - hs0 != 16)
      fail("bp_handshakes", $sformatf("got %0d want 16", n_hs - hs0));

    // Back-to-back 16-QAM words, in_valid held high
    hs0 = n_hs;
    bus.out_ready = 1'b1;
    bus.in_mode = 2'd2;
    bus.in_data = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    cnt = 0;
    run = 0;
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (acc_now) begin
        cnt++;
        bus.in_data = 32'h0;
        if (cnt == 2) bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        run++;
      end else if (seen) begin
        break;
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (run != 16)
      fail("b2b_run", $sformatf("got %0d consecutive valid want 16", run));
    checks++;
    if (n_hs - hs0 != 16)
      fail("b2b_handshakes", $sformatf("got %0d want 16", n_hs - hs0));

    // Illegal mode: one-cycle error pulse, no symbols
    hs0 = n_hs;
    send_word(2'd3, 32'h1234_5678);
    cnt = 0;
    run = 0;
    for (int t = 0; t < 5; t++) begin
      #1;
      if (bus.error) cnt++;
      if (bus.out_valid) run++;
      tick();
    end
    checks++;
    if (cnt != 1) fail("illegal_err_cycles", $sformatf("got %0d want 1", cnt));
    checks++;
    if (run != 0 || n_hs != hs0)
      fail("illegal_no_out", $sformatf("got %0d valid cycles want 0", run));

    // Reset mid BPSK word, then a normal word
    send_word(2'd0, 32'hDEAD_BEEF);
    for (int t = 0; t < 5; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_i !== 16'sd0 || bus.out_q !== 16'sd0 ||
        bus.out_last !== 1'b0)
      fail("midword_rst", $sformatf("got v%0b %0d,%0d,%0b want 0 0,0,0",
           bus.out_valid, bus.out_i, bus.out_q, bus.out_last));
    cap_q.delete();
    base = n_last;
    send_word(2'd2, 32'h0000_36C0);
    wait_last(base);
    tick();
    checks++;
    if (cap_q.size() != 8)
      fail("post_rst_count", $sformatf("got %0d want 8", cap_q.size()));

    // Randomized traffic against the scoreboard
    for (int t = 0; t < 2000; t++) begin
      if (acc_now) bus.in_valid = 1'b0;
      if (!bus.in_valid) begin
        bus.in_mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        bus.in_data = $urandom;
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 80; t++) tick();
    checks++;
    if (exp_q.size() != 0)
      fail("drain", $sformatf("got %0d pending want 0", exp_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
